// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state TAP FSM, instruction register, BYPASS/IDCODE
// data registers, boundary-cell controls and negedge-timed TDO.
module tap_controller #(
   parameter int                IR_LEN       = 4,
   parameter logic [31:0]       IDCODE_VALUE = 32'h1000_0CFF,
   parameter logic [IR_LEN-1:0] OP_EXTEST    = IR_LEN'(0),
   parameter logic [IR_LEN-1:0] OP_SAMPLE    = IR_LEN'(1),
   parameter logic [IR_LEN-1:0] OP_IDCODE    = IR_LEN'(2),
   parameter logic [IR_LEN-1:0] OP_BYPASS    = '1
) (
   input  logic TCK,
   input  logic TRST,
   input  logic TMS,
   input  logic TDI,
   input  logic BSChainTDO,
   output logic TDO,
   output logic TDOEnable,
   output logic CaptureDR,
   output logic ShiftDR,
   output logic UpdateDR,
   output logic ExtestSelected,
   output logic SampleSelected,
   output logic IdcodeSelected,
   output logic BypassSelected,
   output logic TestLogicReset
);

   typedef enum logic [3:0] {
      TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
      SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
   } tap_state_e;

   tap_state_e        state_q, state_d;
   logic [IR_LEN-1:0] ir_sr_q;
   logic [IR_LEN-1:0] ir_active_q;
   logic              bypass_q;
   logic [31:0]       idcode_q;
   logic              capture_dr_q, shift_dr_q, update_dr_q, tlr_q;
   logic              tdo_q, tdo_en_q;
   logic              bs_sel;
   logic              dr_tdo;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         TLR:    state_d = TMS ? TLR    : RTI;
         RTI:    state_d = TMS ? SEL_DR : RTI;
         SEL_DR: state_d = TMS ? SEL_IR : CAP_DR;
         CAP_DR: state_d = TMS ? EX1_DR : SH_DR;
         SH_DR:  state_d = TMS ? EX1_DR : SH_DR;
         EX1_DR: state_d = TMS ? UPD_DR : PAU_DR;
         PAU_DR: state_d = TMS ? EX2_DR : PAU_DR;
         EX2_DR: state_d = TMS ? UPD_DR : SH_DR;
         UPD_DR: state_d = TMS ? SEL_DR : RTI;
         SEL_IR: state_d = TMS ? TLR    : CAP_IR;
         CAP_IR: state_d = TMS ? EX1_IR : SH_IR;
         SH_IR:  state_d = TMS ? EX1_IR : SH_IR;
         EX1_IR: state_d = TMS ? UPD_IR : PAU_IR;
         PAU_IR: state_d = TMS ? EX2_IR : PAU_IR;
         EX2_IR: state_d = TMS ? UPD_IR : SH_IR;
         UPD_IR: state_d = TMS ? SEL_DR : RTI;
         default: state_d = TLR;
      endcase
   end

   assign ExtestSelected = (ir_active_q == OP_EXTEST);
   assign SampleSelected = (ir_active_q == OP_SAMPLE);
   assign IdcodeSelected = (ir_active_q == OP_IDCODE);
   assign BypassSelected = (ir_active_q == OP_BYPASS) |
                           ~(ExtestSelected | SampleSelected | IdcodeSelected);
   assign bs_sel         = ExtestSelected | SampleSelected;

   // Cell controls are registered from the next state so they are clean Moore decodes.
   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) begin
         state_q      <= TLR;
         tlr_q        <= 1'b1;
         capture_dr_q <= 1'b0;
         shift_dr_q   <= 1'b0;
         update_dr_q  <= 1'b0;
         ir_sr_q      <= '0;
         bypass_q     <= 1'b0;
         idcode_q     <= IDCODE_VALUE;
      end else begin
         state_q      <= state_d;
         tlr_q        <= (state_d == TLR);
         capture_dr_q <= bs_sel && (state_d == CAP_DR);
         shift_dr_q   <= bs_sel && (state_d == SH_DR);
         update_dr_q  <= bs_sel && (state_d == UPD_DR);
         case (state_q)
            CAP_IR: ir_sr_q <= IR_LEN'(1);
            SH_IR:  ir_sr_q <= {TDI, ir_sr_q[IR_LEN-1:1]};
            CAP_DR: begin
               if (IdcodeSelected)      idcode_q <= IDCODE_VALUE;
               else if (BypassSelected) bypass_q <= 1'b0;
            end
            SH_DR: begin
               if (IdcodeSelected)      idcode_q <= {TDI, idcode_q[31:1]};
               else if (BypassSelected) bypass_q <= TDI;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      dr_tdo = bypass_q;
      if (bs_sel)              dr_tdo = BSChainTDO;
      else if (IdcodeSelected) dr_tdo = idcode_q[0];
   end

   // Instruction and TDO change on the falling edge so they are stable across the next rising edge.
   always_ff @(negedge TCK or posedge TRST) begin
      if (TRST) begin
         ir_active_q <= OP_IDCODE;
         tdo_q       <= 1'b0;
         tdo_en_q    <= 1'b0;
      end else begin
         if (state_q == UPD_IR)   ir_active_q <= ir_sr_q;
         else if (state_q == TLR) ir_active_q <= OP_IDCODE;
         case (state_q)
            SH_IR: begin
               tdo_q    <= ir_sr_q[0];
               tdo_en_q <= 1'b1;
            end
            SH_DR: begin
               tdo_q    <= dr_tdo;
               tdo_en_q <= 1'b1;
            end
            default: begin
               tdo_q    <= 1'b0;
               tdo_en_q <= 1'b0;
            end
         endcase
      end
   end

   assign TDO            = tdo_q;
   assign TDOEnable      = tdo_en_q;
   assign CaptureDR      = capture_dr_q;
   assign ShiftDR        = shift_dr_q;
   assign UpdateDR       = update_dr_q;
   assign TestLogicReset = tlr_q;

endmodule

// File: tb/tb_tap_controller.sv
// Randomized bench for tap_controller against a table-driven behavioural TAP model.
module tb_tap_controller;

   logic TCK = 1'b0;
   logic TRST = 1'b0, TMS = 1'b1, TDI = 1'b0, BSChainTDO = 1'b0;
   logic TDO, TDOEnable, CaptureDR, ShiftDR, UpdateDR;
   logic ExtestSelected, SampleSelected, IdcodeSelected, BypassSelected, TestLogicReset;

   localparam logic [31:0] IDV = 32'h1000_0CFF;

   tap_controller dut (
      .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .BSChainTDO(BSChainTDO),
      .TDO(TDO), .TDOEnable(TDOEnable), .CaptureDR(CaptureDR), .ShiftDR(ShiftDR),
      .UpdateDR(UpdateDR), .ExtestSelected(ExtestSelected), .SampleSelected(SampleSelected),
      .IdcodeSelected(IdcodeSelected), .BypassSelected(BypassSelected),
      .TestLogicReset(TestLogicReset)
   );

   always #5 TCK = ~TCK;

   // State numbering for the model only.
   localparam int TLR = 0, CDR = 3, SHDR = 4, UDR = 8, CIR = 10, SHIR = 11, UIR = 15;
   int nx0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
   int nx1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

   int          m_state;
   int unsigned m_irsr, m_active;
   logic [31:0] m_id;
   logic        m_byp, m_tdo, m_en;
   int          checks = 0, errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
      end
   endtask

   function automatic bit m_bs();
      return (m_active == 0) || (m_active == 1);
   endfunction

   function automatic void m_reset();
      m_state = TLR; m_irsr = 0; m_active = 2; m_byp = 0; m_id = IDV; m_tdo = 0; m_en = 0;
   endfunction

   task automatic check_sel();
      check("extest_sel", ExtestSelected, m_active == 0);
      check("sample_sel", SampleSelected, m_active == 1);
      check("idcode_sel", IdcodeSelected, m_active == 2);
      check("bypass_sel", BypassSelected, m_active > 2);
   endtask

   task automatic step(input logic tms, input logic tdi);
      TMS = tms; TDI = tdi; BSChainTDO = 1'($urandom);
      @(posedge TCK);
      if (m_state == CIR) m_irsr = 1;
      else if (m_state == SHIR) m_irsr = (m_irsr >> 1) | (int'(tdi) << 3);
      else if (m_state == CDR) begin
         if (m_active == 2) m_id = IDV;
         else if (!m_bs()) m_byp = 0;
      end else if (m_state == SHDR) begin
         if (m_active == 2) m_id = {tdi, m_id[31:1]};
         else if (!m_bs()) m_byp = tdi;
      end
      m_state = tms ? nx1[m_state] : nx0[m_state];
      #1;
      check("tlr", TestLogicReset, m_state == TLR);
      check("capture_dr", CaptureDR, m_bs() && m_state == CDR);
      check("shift_dr", ShiftDR, m_bs() && m_state == SHDR);
      check("update_dr", UpdateDR, m_bs() && m_state == UDR);
      @(negedge TCK);
      if (m_state == UIR) m_active = m_irsr;
      else if (m_state == TLR) m_active = 2;
      m_en  = (m_state == SHIR) || (m_state == SHDR);
      m_tdo = 0;
      if (m_state == SHIR) m_tdo = m_irsr[0];
      else if (m_state == SHDR) m_tdo = m_bs() ? BSChainTDO : (m_active == 2) ? m_id[0] : m_byp;
      #1;
      check("tdo", TDO, m_tdo);
      check("tdo_en", TDOEnable, m_en);
      check_sel();
   endtask

   task automatic pulse_reset();
      #1 TRST = 1'b1;
      #1;
      check("rst_tlr", TestLogicReset, 1);
      check("rst_tdo", TDO, 0);
      check("rst_tdo_en", TDOEnable, 0);
      check("rst_shift_dr", ShiftDR, 0);
      check("rst_capture_dr", CaptureDR, 0);
      check("rst_update_dr", UpdateDR, 0);
      check("rst_idcode_sel", IdcodeSelected, 1);
      check("rst_bypass_sel", BypassSelected, 0);
      @(negedge TCK);
      #2 TRST = 1'b0;
      m_reset();
   endtask

   // From Run-Test/Idle: load op into IR, return to Run-Test/Idle.
   task automatic ir_scan(input logic [3:0] op);
      step(1, 0); step(1, 0); step(0, 0); step(0, 0);
      for (int i = 0; i < 4; i++) step(i == 3, op[i]);
      step(1, 0); step(0, 0);
      $display("IR scan op=%b active_sel ext=%0b smp=%0b id=%0b byp=%0b",
               op, ExtestSelected, SampleSelected, IdcodeSelected, BypassSelected);
   endtask

   // From Run-Test/Idle: n-bit DR scan, optionally detouring through Pause-DR.
   task automatic dr_scan(input int n, input bit pause);
      logic [31:0] cap = '0;
      step(1, 0); step(0, 0); step(0, 0);
      for (int i = 0; i < n; i++) begin
         step(i == n - 1, 1'($urandom));
         cap[i % 32] = TDO;
      end
      if (pause) begin
         step(0, 0); step(0, 0); step(1, 0); step(0, 0);
         step(0, 1'($urandom)); step(1, 1'($urandom));
      end
      step(1, 0); step(0, 0);
      $display("DR scan n=%0d pause=%0d first32=%h", n, pause, cap);
   endtask

   initial begin
      m_reset();
      pulse_reset();
      step(0, 0);
      dr_scan(32, 0);          // IDCODE out after reset
      ir_scan(4'b1111);
      dr_scan(4, 0);           // BYPASS path
      ir_scan(4'b0001);
      dr_scan(8, 1);           // SAMPLE via Pause-DR
      ir_scan(4'b0110);
      dr_scan(5, 1);
      ir_scan(4'b0000);
      dr_scan(6, 0);
      for (int i = 0; i < 5; i++) step(1, 0);
      $display("Five TMS=1 tlr=%0b idcode_sel=%0b", TestLogicReset, IdcodeSelected);
      step(0, 0);
      ir_scan(4'b1111);
      step(1, 0); step(0, 0); step(0, 0); step(0, 1); step(0, 0);
      pulse_reset();            // mid Shift-DR
      $display("Reset mid-scan tlr=%0b shift_dr=%0b", TestLogicReset, ShiftDR);
      for (int n = 0; n < 300; n++) begin
         int r = $urandom_range(0, 99);
         if (r < 3) pulse_reset();
         else if (r < 12) begin
            step(0, 0);
            ir_scan(4'($urandom));
            dr_scan($urandom_range(1, 12), 1'($urandom));
         end else begin
            for (int k = 0; k < 8; k++) step($urandom_range(0, 99) < 35, 1'($urandom));
            $display("Random burst %0d state=%0d", n, m_state);
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
